// File: rtl/fp_pkg.sv
// fp_pkg: shared types, defaults and constant helpers for the pipelined floating-point adder.
package fp_pkg;
    localparam int EXP_W_D = 8;
    localparam int MAN_W_D = 23;
    typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} fp_class_e;
    typedef struct packed {
        logic special;
        logic nan;
        logic isign;
        logic zsign;
        logic sign;
    } ctl_t;
    function automatic int bias(int ew);
        return (1 << (ew - 1)) - 1;
    endfunction
    // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB only.
    function automatic logic [63:0] qnan_bits(int ew, int mw);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < ew; i++) r[mw + i] = 1'b1;
        r[mw - 1] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero counter; returns WD when the input is all zeros.
module fp_lzc #(
    parameter int WD = 28,
    localparam int CW = $clog2(WD + 1)
) (
    input  logic [WD-1:0] d,
    output logic [CW-1:0] cnt
);
    always_comb begin
        cnt = CW'(WD);
        for (int i = 0; i < WD; i++)
            if (d[i]) cnt = CW'(WD - 1 - i);
    end
endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: three-stage IEEE-754 adder/subtractor (align, add, normalise/round) with RNE,
// flush-to-zero, special-value handling and a global valid/ready stall.
module fp_add_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = EXP_W_D,
    parameter int MAN_W = MAN_W_D,
    localparam int W = EXP_W + MAN_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         flg_ovf,
    output logic         flg_unf,
    output logic         flg_nan,
    output logic         flg_inx
);
    localparam int F = MAN_W + 4;
    localparam int LZW = $clog2(F + 2);
    localparam int EW = EXP_W + 2;
    localparam logic [EXP_W-1:0] EMAX = '1;
    localparam logic [EW-1:0] E_INF = EW'(EMAX);
    localparam logic [W-1:0] QNAN = W'(qnan_bits(EXP_W, MAN_W));

    function automatic fp_class_e classify(logic [EXP_W-1:0] e, logic [MAN_W-1:0] f);
        return e == '0 ? CL_ZERO : e != EMAX ? CL_NORM : f == '0 ? CL_INF : CL_NAN;
    endfunction

    logic en;
    fp_class_e ca, cb;
    logic sa, sb, swap;
    logic [W-2:0] ma, mb, mx, my;
    logic [EXP_W-1:0] d, sh;
    logic [F-1:0] sig_x, sig_y, y_sh, y_al;
    ctl_t c1_d, c1, c2;
    logic v1, v2, sub1;
    logic [EXP_W-1:0] e1, e2;
    logic [F-1:0] x1, y1, n;
    logic [F:0] s2_d, s2;
    logic [LZW-1:0] lz2_d, lz2;
    logic [EW-1:0] e_n, e_r;
    logic [MAN_W+1:0] r;
    logic [MAN_W-1:0] frac;
    logic carry, inc, zero, ovf, unf, live;
    logic [W-1:0] res;

    assign en = ~out_valid | out_ready;
    assign in_ready = en;

    // Stage 1: classify, order by magnitude, align the smaller operand.
    assign ca = classify(a[W-2:MAN_W], a[MAN_W-1:0]);
    assign cb = classify(b[W-2:MAN_W], b[MAN_W-1:0]);
    assign sa = a[W-1];
    assign sb = b[W-1] ^ op_sub;
    assign ma = ca == CL_ZERO ? '0 : a[W-2:0];
    assign mb = cb == CL_ZERO ? '0 : b[W-2:0];
    assign swap = mb > ma;
    assign mx = swap ? mb : ma;
    assign my = swap ? ma : mb;
    assign sig_x = {|mx[W-2:MAN_W], mx[MAN_W-1:0], 3'b000};
    assign sig_y = {|my[W-2:MAN_W], my[MAN_W-1:0], 3'b000};
    assign d = mx[W-2:MAN_W] - my[W-2:MAN_W];
    assign sh = d > EXP_W'(F - 1) ? EXP_W'(F - 1) : d;
    assign y_sh = sig_y >> sh;
    assign y_al = {y_sh[F-1:1], y_sh[0] | (|(sig_y & ~({F{1'b1}} << sh)))};
    assign c1_d = '{
        special: ca == CL_INF || ca == CL_NAN || cb == CL_INF || cb == CL_NAN,
        nan:     ca == CL_NAN || cb == CL_NAN || (ca == CL_INF && cb == CL_INF && sa != sb),
        isign:   ca == CL_INF ? sa : sb,
        zsign:   sa & sb,
        sign:    swap ? sb : sa
    };

    // Stage 2: significand add/subtract with one carry bit, then leading-zero count.
    assign s2_d = sub1 ? {1'b0, x1} - {1'b0, y1} : {1'b0, x1} + {1'b0, y1};
    fp_lzc #(.WD(F + 1)) u_lzc (.d(s2_d), .cnt(lz2_d));

    // Stage 3: the count spans the carry bit, so a left shift of lz-1 lands the leading one on the hidden bit.
    assign carry = s2[F];
    assign zero = s2 == '0;
    assign n = carry ? {s2[F:2], |s2[1:0]} : F'(s2 << (lz2 - LZW'(1)));
    assign e_n = EW'(e2) + EW'(1) - (carry ? EW'(0) : EW'(lz2));
    assign inc = n[2] & (n[1] | n[0] | n[3]);
    assign r = {1'b0, n[F-1:3]} + (MAN_W + 2)'(inc);
    assign e_r = e_n + EW'(r[MAN_W+1]);
    assign frac = r[MAN_W+1] ? r[MAN_W:1] : r[MAN_W-1:0];
    assign ovf = ~e_r[EW-1] && e_r >= E_INF;
    assign unf = e_r[EW-1] || e_r == '0;
    assign live = ~c2.special & ~zero;
    assign res = c2.special ? (c2.nan ? QNAN : {c2.isign, EMAX, {MAN_W{1'b0}}})
               : zero ? {c2.zsign, {(W - 1){1'b0}}}
               : ovf ? {c2.sign, EMAX, {MAN_W{1'b0}}}
               : unf ? {c2.sign, {(W - 1){1'b0}}}
               : {c2.sign, e_r[EXP_W-1:0], frac};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            c1 <= '0;
            sub1 <= 1'b0;
            e1 <= '0;
            x1 <= '0;
            y1 <= '0;
            v2 <= 1'b0;
            c2 <= '0;
            e2 <= '0;
            s2 <= '0;
            lz2 <= '0;
            out_valid <= 1'b0;
            sum <= '0;
            flg_ovf <= 1'b0;
            flg_unf <= 1'b0;
            flg_nan <= 1'b0;
            flg_inx <= 1'b0;
        end else if (en) begin
            v1 <= in_valid;
            c1 <= c1_d;
            sub1 <= sa ^ sb;
            e1 <= mx[W-2:MAN_W];
            x1 <= sig_x;
            y1 <= y_al;
            v2 <= v1;
            c2 <= c1;
            e2 <= e1;
            s2 <= s2_d;
            lz2 <= lz2_d;
            out_valid <= v2;
            sum <= res;
            flg_ovf <= live & ovf;
            flg_unf <= live & unf;
            flg_nan <= c2.special & c2.nan;
            flg_inx <= live & (ovf | unf | (|n[2:0]));
        end
    end
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: directed vectors with hand-computed results, scoreboard queue and
// a negedge monitor that checks every presented output, latency and hold-under-stall.
module tb_fp_add_pipe;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, op_sub = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid, flg_ovf, flg_unf, flg_nan, flg_inx;
    logic [31:0] a = '0, b = '0, sum;
    typedef struct {
        logic [31:0] s;
        logic [3:0]  f;
        int          issue;
        bit          lat;
    } exp_t;
    exp_t q[$];
    int cyc = 0, n_vec = 0, n_bad = 0;
    bit seen = 0;

    fp_add_pipe dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op_sub(op_sub), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .flg_ovf(flg_ovf), .flg_unf(flg_unf), .flg_nan(flg_nan), .flg_inx(flg_inx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Flags are packed {ovf, unf, nan, inx}.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q.size() == 0) chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
            else begin
                chk("sum", sum, q[0].s);
                chk("flags", {28'd0, flg_ovf, flg_unf, flg_nan, flg_inx}, {28'd0, q[0].f});
                if (!seen && q[0].lat) chk("latency", 32'(cyc - q[0].issue), 32'd3);
                seen = 1;
                if (out_ready) begin
                    void'(q.pop_front());
                    seen = 0;
                end
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the operands.
    task automatic send(logic [31:0] va, logic [31:0] vb, logic vs, logic [31:0] es, logic [3:0] ef, bit lat);
        bit ok = 0;
        in_valid = 1'b1;
        a = va;
        b = vb;
        op_sub = vs;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            if (ok) q.push_back('{es, ef, cyc, lat});
            @(posedge clk);
            #1;
        end
        if (!ok) chk("accept_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && q.size() != 0; i++) @(posedge clk);
        if (q.size() != 0) chk("drain_timeout", 32'(q.size()), 32'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_flags", {28'd0, flg_ovf, flg_unf, flg_nan, flg_inx}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 1);
        send(32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'h0, 1);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'h0, 1);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'h1, 1);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'h1, 1);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h9, 1);
        send(32'h7F800000, 32'hFF800000, 1'b0, 32'h7FC00000, 4'h2, 1);
        send(32'h00400000, 32'h00000000, 1'b0, 32'h00000000, 4'h0, 1);
        send(32'hFFC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'h2, 1);
        send(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'h0, 1);
        send(32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'h0, 1);
        send(32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'h0, 1);
        send(32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 4'h0, 1);
        send(32'h3F800000, 32'hBF800000, 1'b1, 32'h40000000, 4'h0, 1);
        send(32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'h0, 1);
        send(32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 4'h5, 1);
        send(32'h80800001, 32'h80800000, 1'b1, 32'h80000000, 4'h5, 1);
        send(32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'h0, 1);
        send(32'h3F800000, 32'h33000000, 1'b1, 32'h3F800000, 4'h1, 1);
        send(32'h3F800000, 32'h00800000, 1'b0, 32'h3F800000, 4'h1, 1);
        send(32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001, 4'h1, 1);
        send(32'h3FFFFFFF, 32'h3F800000, 1'b0, 32'h40400000, 4'h1, 1);
        drain();
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, 0);
                send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'h0, 0);
                send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 0);
                send(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 4'h0, 0);
                send(32'h40000000, 32'h3F800000, 1'b1, 32'h3F800000, 4'h0, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
                chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'h0, 0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'h0, 0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'h9, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_sum", sum, 32'd0);
        chk("midrst_flags", {28'd0, flg_ovf, flg_unf, flg_nan, flg_inx}, 32'd0);
        chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        q.delete();
        seen = 0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'h0, 1);
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
